// File: rtl/seqgen_pkg.sv
// Shared types and helpers for the seqgen_param serial sequence generator.
package seqgen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_LOOP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // A length of zero or anything beyond the pattern width means "use the whole pattern".
  function automatic int clamp_len(input int len, input int w);
    return (len == 0 || len > w) ? w : len;
  endfunction

endpackage

// File: rtl/seqgen_if.sv
// Control/serial-output bundle between a register-side controller and seqgen_param.
interface seqgen_if #(
  parameter int W  = 8,
  parameter int LW = $clog2(W+1)
) ();

  logic          load;
  logic [W-1:0]  pat_in;
  logic [LW-1:0] len_in;
  logic          start;
  logic          stop;
  logic          mode;
  logic          msb_first;

  logic          ds;
  logic          ds_valid;
  logic [LW-1:0] idx;
  logic          busy;
  logic          wrap;
  logic          done;

  modport master (
    output load, pat_in, len_in, start, stop, mode, msb_first,
    input  ds, ds_valid, idx, busy, wrap, done
  );

  modport slave (
    input  load, pat_in, len_in, start, stop, mode, msb_first,
    output ds, ds_valid, idx, busy, wrap, done
  );

endinterface

// File: rtl/seqgen_index.sv
// Up/down pattern index counter: loads the first index of a pass, detects the last one,
// and restarts from the first index when advanced past it.
module seqgen_index #(
  parameter int W  = 8,
  parameter int LW = $clog2(W+1)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          clr,
  input  logic          init,
  input  logic          adv,
  input  logic          dn,
  input  logic [LW-1:0] len_cur,
  input  logic [LW-1:0] len_nxt,
  output logic [LW-1:0] idx,
  output logic [LW-1:0] idx_nxt,
  output logic          last,
  output logic          last_nxt
);

  logic [LW-1:0] first;

  // len_cur governs the pass on display; len_nxt may differ when a new length lands at a boundary.
  always_comb begin
    first    = dn ? (len_nxt - LW'(1)) : '0;
    last     = dn ? (idx == '0) : (idx == len_cur - LW'(1));
    idx_nxt  = idx;
    if (clr)
      idx_nxt = '0;
    else if (init || (adv && last))
      idx_nxt = first;
    else if (adv)
      idx_nxt = dn ? (idx - LW'(1)) : (idx + LW'(1));
    last_nxt = dn ? (idx_nxt == '0) : (idx_nxt == len_nxt - LW'(1));
  end

  always_ff @(posedge clk) begin
    if (!clrn) idx <= '0;
    else       idx <= idx_nxt;
  end

endmodule

// File: rtl/seqgen_param.sv
// Serial sequence generator: emits an L-bit prefix of a W-bit pattern, one bit per clock.
// Define SEQGEN_SHADOW_EN to let loads during a run be staged and applied at the next pass boundary.
module seqgen_param
  import seqgen_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = $clog2(W+1)
) (
  input logic     clk,
  input logic     clrn,
  seqgen_if.slave bus
);

  state_t        state, state_nxt;
  logic [W-1:0]  pat_reg, pat_nxt;
  logic [LW-1:0] len_reg, len_nxt, len_in_c;
  logic          mode_q, mode_nxt;
  logic          order_q, order_nxt;
  logic          clr, init, adv, dn;
  logic [LW-1:0] idx_q, idx_nxt;
  logic          last, last_nxt;
  logic          run_nxt;
  logic [W-1:0]  pat_sh;

`ifdef SEQGEN_SHADOW_EN
  logic [W-1:0]  sh_pat, sh_pat_nxt;
  logic [LW-1:0] sh_len, sh_len_nxt;
  logic          pend, pend_nxt;
  logic          apply;
`endif

  always_comb begin
    len_in_c  = LW'(clamp_len(int'(bus.len_in), W));
    state_nxt = state;
    pat_nxt   = pat_reg;
    len_nxt   = len_reg;
    mode_nxt  = mode_q;
    order_nxt = order_q;
    clr       = 1'b0;
    init      = 1'b0;
    adv       = 1'b0;
`ifdef SEQGEN_SHADOW_EN
    sh_pat_nxt = sh_pat;
    sh_len_nxt = sh_len;
    pend_nxt   = pend;
    apply      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.load) begin
          pat_nxt = bus.pat_in;
          len_nxt = len_in_c;
        end
        if (bus.start && !bus.stop) begin
          state_nxt = RUN;
          init      = 1'b1;
          mode_nxt  = bus.mode;
          order_nxt = bus.msb_first;
        end
      end
      RUN: begin
`ifdef SEQGEN_SHADOW_EN
        if (bus.load) begin
          sh_pat_nxt = bus.pat_in;
          sh_len_nxt = len_in_c;
          pend_nxt   = 1'b1;
        end
`endif
        if (bus.stop) begin
          state_nxt = IDLE;
          clr       = 1'b1;
`ifdef SEQGEN_SHADOW_EN
          apply     = 1'b1;
`endif
        end else if (last) begin
`ifdef SEQGEN_SHADOW_EN
          apply = 1'b1;
`endif
          if (mode_q == MODE_ONESHOT) begin
            state_nxt = IDLE;
            clr       = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end else begin
          adv = 1'b1;
        end
`ifdef SEQGEN_SHADOW_EN
        // A load in the boundary cycle itself goes straight into the next pass.
        if (apply && pend_nxt) begin
          pat_nxt  = sh_pat_nxt;
          len_nxt  = sh_len_nxt;
          pend_nxt = 1'b0;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    dn      = (state == IDLE) ? bus.msb_first : order_q;
    run_nxt = (state_nxt == RUN);
  end

  seqgen_index #(.W(W), .LW(LW)) u_index (
    .clk      (clk),
    .clrn     (clrn),
    .clr      (clr),
    .init     (init),
    .adv      (adv),
    .dn       (dn),
    .len_cur  (len_reg),
    .len_nxt  (len_nxt),
    .idx      (idx_q),
    .idx_nxt  (idx_nxt),
    .last     (last),
    .last_nxt (last_nxt)
  );

  assign pat_sh  = pat_nxt >> idx_nxt;
  assign bus.idx = idx_q;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state        <= IDLE;
      pat_reg      <= '0;
      len_reg      <= LW'(W);
      mode_q       <= MODE_LOOP;
      order_q      <= 1'b0;
      bus.ds       <= 1'b0;
      bus.ds_valid <= 1'b0;
      bus.busy     <= 1'b0;
      bus.wrap     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      pat_reg      <= pat_nxt;
      len_reg      <= len_nxt;
      mode_q       <= mode_nxt;
      order_q      <= order_nxt;
      bus.ds       <= run_nxt & pat_sh[0];
      bus.ds_valid <= run_nxt;
      bus.busy     <= run_nxt;
      bus.wrap     <= run_nxt & last_nxt;
      bus.done     <= run_nxt & last_nxt & (mode_nxt == MODE_ONESHOT);
    end
  end

`ifdef SEQGEN_SHADOW_EN
  always_ff @(posedge clk) begin
    if (!clrn) begin
      sh_pat <= '0;
      sh_len <= LW'(W);
      pend   <= 1'b0;
    end else begin
      sh_pat <= sh_pat_nxt;
      sh_len <= sh_len_nxt;
      pend   <= pend_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_seqgen_param.sv
// Scoreboard bench for seqgen_param: stimulus queues expected bits, a negedge monitor checks them.
module tb_seqgen_param;

  localparam int W  = 8;
  localparam int LW = $clog2(W+1);

  typedef struct packed {
    logic          ds;
    logic [LW-1:0] idx;
    logic          wrap;
    logic          done;
  } exp_t;

  logic  clk  = 1'b0;
  logic  clrn = 1'b0;
  exp_t  q[$];
  exp_t  e;
  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 1'b0;
  string tag      = "reset";

  seqgen_if #(.W(W)) bus ();

  seqgen_param #(.W(W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s/%s: got %0h want %0h at %0t", tag, name, got, want, $time);
    end
  endtask

  task automatic push(input logic d, input int i, input logic w, input logic dn);
    exp_t x;
    x.ds   = d;
    x.idx  = LW'(i);
    x.wrap = w;
    x.done = dn;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call in the first bit's cycle; shows n bits with stop sampled on the last, then one idle cycle.
  task automatic run_stop(input int n);
    repeat (n-1) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.ds_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s/unexpected_bit: got ds=%0b idx=%0d want no valid bit", tag, bus.ds, bus.idx);
        end else begin
          e = q.pop_front();
          chk("ds",   16'(bus.ds),   16'(e.ds));
          chk("idx",  16'(bus.idx),  16'(e.idx));
          chk("wrap", 16'(bus.wrap), 16'(e.wrap));
          chk("done", 16'(bus.done), 16'(e.done));
          chk("busy", 16'(bus.busy), 16'd1);
        end
      end else begin
        chk("idle_valid", 16'(bus.ds_valid), 16'd0);
        chk("idle_ds",    16'(bus.ds),       16'd0);
        chk("idle_idx",   16'(bus.idx),      16'd0);
        chk("idle_wrap",  16'(bus.wrap),     16'd0);
        chk("idle_done",  16'(bus.done),     16'd0);
        chk("idle_busy",  16'(bus.busy),     16'd0);
      end
    end
  end

  logic t1[8] = '{0, 1, 0, 0, 1, 1, 0, 1};   // 8'b1011_0010 from bit 0 up
  logic t4[8] = '{1, 0, 1, 1, 0, 0, 1, 0};   // same pattern from bit 7 down

  initial begin
    bus.load = 0; bus.pat_in = '0; bus.len_in = '0; bus.start = 0;
    bus.stop = 0; bus.mode = 0; bus.msb_first = 0;
    tick();
    mon_en = 1'b1;
    tick();
    clrn = 1'b1;
    tick();

    // full-length loop, LSB first, two passes
    tag = "loop_lsb";
    bus.pat_in = 8'b1011_0010; bus.len_in = 0; bus.load = 1;
    tick();
    bus.load = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) push(t1[i], i, i == 7, 0);
    bus.mode = 0; bus.msb_first = 0; bus.start = 1;
    tick();
    bus.start = 0;
    run_stop(16);

    // one-shot, MSB first, length 5, load and start in the same cycle
    tag = "oneshot_msb";
    bus.len_in = 5; bus.mode = 1; bus.msb_first = 1; bus.load = 1; bus.start = 1;
    push(1, 4, 0, 0); push(0, 3, 0, 0); push(0, 2, 0, 0); push(1, 1, 0, 0); push(0, 0, 1, 1);
    tick();
    bus.load = 0; bus.start = 0;
    repeat (6) tick();

    // stop on the third bit; a start held into RUN is ignored
    tag = "stop_third";
    bus.mode = 0; bus.msb_first = 0;
    push(0, 0, 0, 0); push(1, 1, 0, 0); push(0, 2, 0, 0);
    bus.start = 1;
    tick();
    tick();
    bus.start = 0;
    tick();
    bus.stop = 1;
    tick();
    bus.stop = 0;
    tick();

    // stop beats start in IDLE
    tag = "stop_beats_start";
    bus.start = 1; bus.stop = 1;
    tick();
    bus.start = 0; bus.stop = 0;
    repeat (2) tick();

    // length above W clamps to W, MSB-first loop
    tag = "clamp_msb";
    bus.len_in = 12; bus.load = 1;
    tick();
    bus.load = 0;
    for (int i = 0; i < 8; i++) push(t4[i], 7 - i, i == 7, 0);
    bus.mode = 0; bus.msb_first = 1; bus.start = 1;
    tick();
    bus.start = 0;
    run_stop(8);

    // reset mid-run, then a start emits the cleared pattern at full length
    tag = "reset_midrun";
    bus.pat_in = 8'hA5; bus.len_in = 0; bus.load = 1;
    tick();
    bus.load = 0;
    push(1, 0, 0, 0); push(0, 1, 0, 0);
    bus.msb_first = 0; bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    tick();
    tag = "after_reset";
    for (int i = 0; i < 8; i++) push(0, i, i == 7, 0);
    bus.start = 1;
    tick();
    bus.start = 0;
    run_stop(8);

    // length 1 loop: every cycle is a pass end
    tag = "len1_loop";
    bus.pat_in = 8'h01; bus.len_in = 1; bus.load = 1;
    tick();
    bus.load = 0;
    for (int i = 0; i < 4; i++) push(1, 0, 1, 0);
    bus.start = 1;
    tick();
    bus.start = 0;
    run_stop(4);

    // load during a run: staged to next pass with shadowing, otherwise ignored
    tag = "load_in_run";
    bus.pat_in = 8'h00; bus.len_in = 0; bus.load = 1;
    tick();
    bus.load = 0;
    for (int i = 0; i < 8; i++) push(0, i, i == 7, 0);
`ifdef SEQGEN_SHADOW_EN
    for (int i = 0; i < 8; i++) push(1, i, i == 7, 0);
`else
    for (int i = 0; i < 8; i++) push(0, i, i == 7, 0);
`endif
    bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    tick();
    bus.pat_in = 8'hFF; bus.len_in = 0; bus.load = 1;
    tick();
    bus.load = 0;
    repeat (12) tick();
    bus.stop = 1;
    tick();
    bus.stop = 0;
    tick();

    tag = "end";
    chk("queue_empty", 16'(q.size()), 16'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seqgen_param.md
# seqgen_param

Parametrised serial sequence generator, next generation of the 8-bit counter + 8:1 mux sequencer. Holds a W-bit pattern register, emits a programmable-length prefix of it one bit per clock, LSB- or MSB-first, in looping or one-shot mode, with start/stop control and status pulses. Sits between a register-loaded control source and any serial consumer (shift chain, LED, test pin).

## Interface
- W, 8, pattern width and maximum sequence length (W >= 2)
- LW, $clog2(W+1), width of length field and index output

- clk  in  1  system clock; all logic on rising edge
- clrn  in  1  reset, synchronous, active-low
- load  in  1  capture pat_in/len_in into pattern/length registers
- pat_in  in  W  pattern; bit i emitted at index i
- len_in  in  LW  sequence length; 0 or >W clamps to W
- start  in  1  begin emission (IDLE only)
- stop  in  1  abort emission
- mode  in  1  0 = loop, 1 = one-shot; sampled at start
- msb_first  in  1  0 = bit 0 first, 1 = bit L-1 first; sampled at start
- ds  out  1  serial data, registered
- ds_valid  out  1  ds carries a sequence bit this cycle
- idx  out  LW  pattern index of current ds bit
- busy  out  1  state is RUN
- wrap  out  1  one-cycle pulse coincident with last bit of every pass
- done  out  1  one-cycle pulse coincident with last bit of a one-shot pass

## Operation
- States: IDLE, RUN. Reset (clrn=0 at edge): IDLE; pat_reg=0, len_reg=W; ds=0, ds_valid=0, idx=0, busy=0, wrap=0, done=0. Reset mid-run aborts immediately, no done/wrap.
- L = len_reg after clamp (1..W).
- IDLE + load: pat_reg<=pat_in, len_reg<=clamp(len_in).
- IDLE + start (stop=0): go RUN; latch mode and bit order. Same-cycle load+start: sequence uses the newly presented pat_in/len_in.
- RUN: each cycle ds=pat_reg[idx], ds_valid=1. LSB-first idx 0,1..L-1; MSB-first L-1..0.
- Pass end (last index): wrap=1. Loop: next cycle restarts at first index, no gap. One-shot: done=1 too, then IDLE; ds_valid=0, ds=0 next cycle.
- stop in RUN: next cycle IDLE, ds_valid=0, ds=0, no done/wrap. stop beats start; stop in IDLE ignored.
- start while RUN ignored. load while RUN: see Configuration.
- L=1: every RUN cycle is a pass end (wrap each cycle in loop).
- ds=0 and idx=0 whenever ds_valid=0.

## Timing
- Start latency: start sampled at edge k -> first bit valid in cycle after edge k (1 cycle).
- Throughput: 1 bit/clock, continuous across loop passes.
- Stop latency: 1 cycle; bit sampled with stop still shown that cycle.
- busy asserts/deasserts at the same edge as ds_valid.
- All outputs registered; no combinational input-to-output path.

## Configuration
- SEQGEN_SHADOW_EN defined: load in RUN captures pat_in/len_in into shadow registers and sets pending; at the next pass boundary shadow copies to pat_reg/len_reg and the following pass uses them; pending clears. Later load before boundary overwrites shadow. One-shot ending with pending: applied on return to IDLE.
- Not defined: load in RUN ignored; no shadow registers.

## Structure
- Package seqgen_pkg: state enum (IDLE, RUN), mode constants (MODE_LOOP=0, MODE_ONESHOT=1), length-clamp function.
- Sub-module seqgen_index: parametrised up/down index counter with load-to-first-index, last-index detect and wrap; the top holds FSM, pattern/shadow registers and output mux.

## Test plan
- W=8, load pat=8'b1011_0010, len=0 (->8), start mode=0 LSB-first -> ds 0,1,0,0,1,1,0,1 repeating, wrap each 8th cycle, done never.
- Same pattern, len=5, mode=1, MSB-first -> ds bits 4..0 = 1,0,0,1,0; done+wrap on 5th bit; ds_valid low next cycle, busy=0.
- Loop run, assert stop on 3rd bit -> 3rd bit shown, IDLE next cycle, ds=0, no done/wrap.
- clrn=0 mid-run -> next cycle all outputs 0, len_reg=8, pat_reg=0; start afterward emits all zeros.
- len=1 loop, pat bit0=1 -> ds=1 every cycle, wrap every cycle.
- SEQGEN_SHADOW_EN: load pat=8'hFF mid-pass of 8'h00 loop -> remainder of pass 0s, next pass all 1s; without macro stays 0s.
